// File: rtl/alu_op_sequencer_if.sv
// Command and result channels of the ALU operand sequencer.
// The master side offers commands and consumes results; the slave side is the sequencer.
interface alu_op_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] cmd_op;
    logic       cmd_chain;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, res_ready,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, res_ready,
        output cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registers ALU operands from a command handshake, waits for the ALU to settle,
// then captures the result word into a first-word-fall-through FIFO.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    alu_op_sequencer_if.slave           bus,
    output logic [3:0]                  alu_a,
    output logic [3:0]                  alu_b,
    output logic [3:0]                  alu_op,
    input  logic [7:0]                  alu_res,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [7:0]                  err_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] settle_q;
    logic [3:0]       last_result;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             accept, push, pop;

    // NOTE: state is IDLE during reset, so rst_n must gate cmd_ready to keep it low.
    assign bus.cmd_ready = rst_n && (state_q == IDLE)
                           && (fifo_count < (PTR_W + 1)'(FIFO_DEPTH));
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign push          = (state_q == CAPTURE);
    assign pop           = bus.res_ready && bus.res_valid;
    assign bus.res_valid = (fifo_count != '0);
    assign bus.res_data  = bus.res_valid ? mem[rd_ptr] : 8'h00;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (SETTLE_CYCLES == 0) ? CAPTURE : WAIT;
            WAIT:    if (settle_q == CNT_W'(1)) state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            last_result <= '0;
            err_count   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a    <= bus.cmd_chain ? last_result : bus.cmd_a;
                alu_b    <= bus.cmd_b;
                alu_op   <= bus.cmd_op;
                settle_q <= CNT_W'(SETTLE_CYCLES);
            end else if (state_q == WAIT) begin
                settle_q <= settle_q - CNT_W'(1);
            end
            if (push) begin
                last_result <= alu_res[3:0];
                if (alu_res[4] && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            end
        end
    end

    // NOTE: storage is left unreset; res_data is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= alu_res;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small 4-bit ALU model on the alu_* side.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_op_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] alu_a, alu_b, alu_op;
    logic [7:0] alu_res;
    logic [2:0] fifo_count;
    logic [7:0] err_count;
    int         checks = 0;
    int         errors = 0;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.SETTLE_CYCLES(1), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_res    (alu_res),
        .fifo_count (fifo_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // ALU model: 0 add, 1 subtract, 2 and, 3 divide; word is {Z,C,S,E,R}.
    function automatic logic [7:0] alu_model(input logic [3:0] a, b, op);
        logic [4:0] wide;
        logic [3:0] r;
        logic       c, e;
        wide = '0; c = 1'b0; e = 1'b0;
        case (op)
            4'd0: wide = {1'b0, a} + {1'b0, b};
            4'd1: wide = {1'b0, a} - {1'b0, b};
            4'd2: wide = {1'b0, a & b};
            4'd3: if (b == 4'd0) e = 1'b1; else wide = {1'b0, a / b};
            default: e = 1'b1;
        endcase
        r = wide[3:0];
        c = wide[4];
        return {(r == 4'd0), c, r[3], e, r};
    endfunction

    assign alu_res = alu_model(alu_a, alu_b, alu_op);

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic       chain;
        logic [3:0] exp_a;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] a, b, op, input logic chain);
        bit ok = 1'b0;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_chain = chain;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.cmd_ready;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        if (!ok) check("issue_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_res();
        for (int i = 0; i < 20 && !bus.res_valid; i++) @(negedge clk);
        check("res_valid_wait", 32'(bus.res_valid), 32'd1);
    endtask

    task automatic wait_count(input int n);
        for (int i = 0; i < 20 && (fifo_count != 3'(n)); i++) @(negedge clk);
        check("count_wait", 32'(fifo_count), 32'(n));
    endtask

    task automatic pop();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] drain_exp [4];
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
        bus.cmd_chain = 1'b0; bus.res_ready = 1'b0;

        vecs[0] = '{4'h3, 4'h4, 4'd0, 1'b0, 4'h3, 8'h07};
        vecs[1] = '{4'h9, 4'h8, 4'd0, 1'b0, 4'h9, 8'h41};
        vecs[2] = '{4'h5, 4'h0, 4'd3, 1'b0, 4'h5, 8'h90};
        vecs[3] = '{4'h3, 4'h4, 4'd0, 1'b0, 4'h3, 8'h07};
        vecs[4] = '{4'hF, 4'h2, 4'd0, 1'b1, 4'h7, 8'h29};
        vecs[5] = '{4'h2, 4'h5, 4'd1, 1'b0, 4'h2, 8'h6D};
        vecs[6] = '{4'h7, 4'h7, 4'd1, 1'b0, 4'h7, 8'h80};
        vecs[7] = '{4'hC, 4'hA, 4'd2, 1'b0, 4'hC, 8'h28};
        vecs[8] = '{4'h9, 4'h2, 4'd3, 1'b0, 4'h9, 8'h04};
        vecs[9] = '{4'h0, 4'h3, 4'd0, 1'b1, 4'h4, 8'h07};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_alu_abop", 32'({alu_a, alu_b, alu_op}), 32'd0);
        check("rst_counts", 32'({fifo_count, err_count}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Accept-to-result timing with SETTLE_CYCLES=1
        check("idle_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_a = 4'h3; bus.cmd_b = 4'h4; bus.cmd_op = 4'h0; bus.cmd_chain = 1'b0;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("t1_alu_a", 32'(alu_a), 32'h3);
        check("t1_alu_b", 32'(alu_b), 32'h4);
        check("t1_ready_low", 32'(bus.cmd_ready), 32'd0);
        check("t1_res_valid_low", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        check("t2_ready_low", 32'(bus.cmd_ready), 32'd0);
        check("t2_res_valid_low", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        check("t3_res_valid", 32'(bus.res_valid), 32'd1);
        check("t3_res_data", 32'(bus.res_data), 32'h07);
        check("t3_ready_high", 32'(bus.cmd_ready), 32'd1);
        check("t3_alu_a_held", 32'(alu_a), 32'h3);
        pop();
        check("t4_empty", 32'(bus.res_valid), 32'd0);

        // Table-driven vectors, including chaining
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].chain);
            check($sformatf("vec%0d_alu_a", i), 32'(alu_a), 32'(vecs[i].exp_a));
            wait_res();
            check($sformatf("vec%0d_res", i), 32'(bus.res_data), 32'(vecs[i].exp_res));
            pop();
        end
        check("vec_err_count", 32'(err_count), 32'd1);

        // Fill the FIFO, hold a command against backpressure, then pop
        for (int i = 1; i <= 4; i++) issue(4'(i), 4'h1, 4'h0, 1'b0);
        wait_count(4);
        bus.cmd_a = 4'h8; bus.cmd_b = 4'h1; bus.cmd_op = 4'h0; bus.cmd_chain = 1'b0;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("full_ready_low", 32'(bus.cmd_ready), 32'd0);
            @(negedge clk);
        end
        check("full_head", 32'(bus.res_data), 32'h02);
        pop();
        check("pop_ready_high", 32'(bus.cmd_ready), 32'd1);
        check("pop_count", 32'(fifo_count), 32'd3);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("held_cmd_alu_a", 32'(alu_a), 32'h8);
        @(negedge clk);
        check("pushpop_head", 32'(bus.res_data), 32'h03);
        pop();
        check("pushpop_count", 32'(fifo_count), 32'd3);
        drain_exp = '{8'h04, 8'h05, 8'h29, 8'h00};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("drain%0d_valid", i), 32'(bus.res_valid), 32'd1);
            check($sformatf("drain%0d_data", i), 32'(bus.res_data), 32'(drain_exp[i]));
            pop();
        end
        check("drain_count", 32'(fifo_count), 32'd0);

        // Reset during WAIT with two entries queued
        issue(4'h1, 4'h1, 4'h0, 1'b0);
        issue(4'h2, 4'h2, 4'h0, 1'b0);
        issue(4'h3, 4'h3, 4'h0, 1'b0);
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_res_data", 32'(bus.res_data), 32'd0);
        check("mid_rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        check("mid_rst_counts", 32'({fifo_count, err_count}), 32'd0);
        check("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_no_entry", 32'(bus.res_valid), 32'd0);
        issue(4'hA, 4'h5, 4'h0, 1'b1);
        check("post_rst_chain_a", 32'(alu_a), 32'h0);
        wait_res();
        check("post_rst_res", 32'(bus.res_data), 32'h05);
        pop();

        // Error counter saturation
        for (int i = 0; i < 256; i++) begin
            issue(4'h5, 4'h0, 4'h3, 1'b0);
            wait_res();
            pop();
            if (i == 254) check("err_255", 32'(err_count), 32'd255);
        end
        check("err_saturated", 32'(err_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
